// File: rtl/pwm_deadtime_io_if.sv
// MMIO slot bus between the host register block and the PWM dead-time output stage.
// Latency: read_data is combinational from addr; writes are captured on the next clk edge.
// Backpressure: none; the slot always accepts cs&write and always answers a read.
// Signals: addr (word address), cs (slot select), read/write strobes, write_data, read_data.
interface pwm_deadtime_io_if;
  logic [4:0]  addr;
  logic        cs;
  logic        read;
  logic        write;
  logic [31:0] write_data;
  logic [31:0] read_data;

  modport master (
    output addr, cs, read, write, write_data,
    input  read_data
  );

  modport slave (
    input  addr, cs, read, write, write_data,
    output read_data
  );
endinterface

// File: rtl/pwm_deadtime_io.sv
// Complementary gate drive with programmable dead time and latched fault shutdown for 4 PWM channels.
// Latency: active side drops on the edge that samples a pwm edge; opposite side rises DT edges later.
// Backpressure: none; MMIO writes always accepted, reads combinational and side-effect free.
// Ports: clk, rst_n (async active-low); bus (MMIO slot, slave side);
//   i_pwm_in[3:0] raw PWM; i_fault_n async active-low fault; o_gate_hi/o_gate_lo[3:0] gate drives.
module pwm_deadtime_io #(
  parameter int DT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  pwm_deadtime_io_if.slave  bus,
  input  logic [3:0]        i_pwm_in,
  input  logic              i_fault_n,
  output logic [3:0]        o_gate_hi,
  output logic [3:0]        o_gate_lo
);

  typedef enum logic [2:0] {
    ST_OFF  = 3'd0,
    ST_DT_H = 3'd1,
    ST_HI   = 3'd2,
    ST_DT_L = 3'd3,
    ST_LO   = 3'd4
  } state_t;

  // Register file
  logic [3:0]      r_ctrl;
  logic [DT_W-1:0] r_dt;
  logic            r_fault_latched;
  logic            r_sync1;
  logic            r_sync2;

  // Per-channel FSM state
  state_t          r_state   [4];
  state_t          w_state_nxt [4];
  logic [DT_W-1:0] r_cnt     [4];
  logic [DT_W-1:0] w_cnt_nxt [4];
  logic [3:0]      r_hi;
  logic [3:0]      r_lo;
  logic [3:0]      w_hi_nxt;
  logic [3:0]      w_lo_nxt;

  logic            w_wr;
  logic            w_fault_sync;
  logic            w_fault_clr;
  logic            w_kill;
  logic            w_any_active;
  logic            w_unused;

  assign w_wr         = bus.cs & bus.write;
  assign w_fault_sync = ~r_sync2;
  assign w_fault_clr  = w_wr && (bus.addr == 5'd3) && bus.write_data[0];
  // A synchronized fault shuts the channels down one edge ahead of the latch, so a
  // short fault and a CTRL write landing together can never let a channel start.
  assign w_kill       = r_fault_latched | w_fault_sync;
  assign w_any_active = |(r_hi | r_lo);
  assign w_unused     = ^{bus.read, bus.write_data[31:DT_W]};

  assign o_gate_hi = r_hi;
  assign o_gate_lo = r_lo;

  // Registers, synchronizer and fault latch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ctrl          <= 4'h0;
      r_dt            <= '0;
      r_fault_latched <= 1'b0;
      r_sync1         <= 1'b1;
      r_sync2         <= 1'b1;
    end else begin
      r_sync1 <= i_fault_n;
      r_sync2 <= r_sync1;
      if (w_wr && (bus.addr == 5'd0)) r_ctrl <= bus.write_data[3:0];
      if (w_wr && (bus.addr == 5'd1)) r_dt   <= bus.write_data[DT_W-1:0];
      // An active fault always wins over a coincident clear.
      if (w_fault_sync)     r_fault_latched <= 1'b1;
      else if (w_fault_clr) r_fault_latched <= 1'b0;
    end
  end

  // Read mux
  always_comb begin
    bus.read_data = 32'h0;
    case (bus.addr)
      5'd0:    bus.read_data = {28'h0, r_ctrl};
      5'd1:    bus.read_data = 32'(r_dt);
      5'd2:    bus.read_data = {29'h0, w_fault_sync, r_fault_latched, w_any_active};
      default: bus.read_data = 32'h0;
    endcase
  end

  // Channel FSM state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int n = 0; n < 4; n++) begin
        r_state[n] <= ST_OFF;
        r_cnt[n]   <= '0;
      end
      r_hi <= 4'h0;
      r_lo <= 4'h0;
    end else begin
      for (int n = 0; n < 4; n++) begin
        r_state[n] <= w_state_nxt[n];
        r_cnt[n]   <= w_cnt_nxt[n];
      end
      r_hi <= w_hi_nxt;
      r_lo <= w_lo_nxt;
    end
  end

  // Channel FSM next-state. Leaving HI/LO loads DT-1 because the edge that drops the
  // active side already counts as the first dead-time cycle; a restart or entry from
  // OFF loads the full DT.
  always_comb begin
    for (int n = 0; n < 4; n++) begin
      w_state_nxt[n] = r_state[n];
      w_cnt_nxt[n]   = r_cnt[n];
      w_hi_nxt[n]    = 1'b0;
      w_lo_nxt[n]    = 1'b0;
      if (!r_ctrl[n] || w_kill) begin
        w_state_nxt[n] = ST_OFF;
        w_cnt_nxt[n]   = '0;
      end else begin
        case (r_state[n])
          ST_OFF: begin
            w_cnt_nxt[n]   = r_dt;
            w_state_nxt[n] = i_pwm_in[n] ? ST_DT_H : ST_DT_L;
          end
          ST_DT_H: begin
            if (!i_pwm_in[n]) begin
              w_state_nxt[n] = ST_DT_L;
              w_cnt_nxt[n]   = r_dt;
            end else if (r_cnt[n] == '0) begin
              w_state_nxt[n] = ST_HI;
              w_hi_nxt[n]    = 1'b1;
            end else begin
              w_cnt_nxt[n]   = r_cnt[n] - DT_W'(1);
            end
          end
          ST_HI: begin
            w_hi_nxt[n] = 1'b1;
            if (!i_pwm_in[n]) begin
              w_hi_nxt[n] = 1'b0;
              if (r_dt == '0) begin
                w_state_nxt[n] = ST_LO;
                w_lo_nxt[n]    = 1'b1;
              end else begin
                w_state_nxt[n] = ST_DT_L;
                w_cnt_nxt[n]   = r_dt - DT_W'(1);
              end
            end
          end
          ST_DT_L: begin
            if (i_pwm_in[n]) begin
              w_state_nxt[n] = ST_DT_H;
              w_cnt_nxt[n]   = r_dt;
            end else if (r_cnt[n] == '0) begin
              w_state_nxt[n] = ST_LO;
              w_lo_nxt[n]    = 1'b1;
            end else begin
              w_cnt_nxt[n]   = r_cnt[n] - DT_W'(1);
            end
          end
          ST_LO: begin
            w_lo_nxt[n] = 1'b1;
            if (i_pwm_in[n]) begin
              w_lo_nxt[n] = 1'b0;
              if (r_dt == '0) begin
                w_state_nxt[n] = ST_HI;
                w_hi_nxt[n]    = 1'b1;
              end else begin
                w_state_nxt[n] = ST_DT_H;
                w_cnt_nxt[n]   = r_dt - DT_W'(1);
              end
            end
          end
          default: begin
            w_state_nxt[n] = ST_OFF;
            w_cnt_nxt[n]   = '0;
          end
        endcase
      end
    end
  end

endmodule
